fp_addsub_seq: RTL and testbench
================================

// Module: fp_addsub_seq
// PURPOSE
//  Multi-cycle FP add/sub sequencer around one mantissa_cal instance: unpack, align, add/sub, normalise, round, pack.
//  Sits between an operand producer and result consumer; valid/ready on both sides, one operation in flight.
//  Trades area for latency: normalisation left-shifts one bit per cycle (data-dependent latency).
// PARAMETERS
//  data_format  `FP32  format selector; widths from shared macros: E=`GET_EXP_LEN, M=`GET_MANTISSA_LEN, P=`GET_PROTECT_LEN
//  Derived: N=1+E+M (word), W=1+M+P (hidden+mantissa+guard/round/sticky), mantissa_cal result W+1
// PORTS
//  clk        in   1  clock, all state on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  in_valid   in   1  operands valid
//  in_ready   out  1  accepting operands (high only in IDLE)
//  a          in   N  operand A (IEEE layout)
//  b          in   N  operand B
//  op         in   1  `ADD (0): a+b; `SUB (1): a-b
//  out_valid  out  1  result valid, held until out_ready
//  out_ready  in   1  consumer accepts result
//  result     out  N  rounded IEEE result (RNE)
//  ovf        out  1  overflow to infinity, qualified by out_valid
//  busy       out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset (rst_n low, any state): state=IDLE, in_ready=1, out_valid=0, result=0, ovf=0, busy=0; in-flight op discarded.
//  Accept: in_valid&in_ready. Capture a, b with b sign inverted when op=`SUB. Subnormal: hidden=0, exp=1.
//  IDLE: on accept, special inputs -> DONE next cycle: any NaN or (+Inf)+(-Inf) -> canonical qNaN (exp all 1s, mant MSB 1, sign 0);
//    single Inf or same-sign Infs -> that Inf. Otherwise -> ALIGN.
//  ALIGN (1 cyc): order operands so larger exponent is first (tie keeps a); barrel-shift smaller mantissa right by
//    diff saturated at W; shifted-out bits ORed into sticky LSB. Register sign of larger-exp operand as aligned_sign.
//  CALC (1 cyc): drive mantissa_cal; register cal_result, cal_sign. cal_result==0 -> result=+0, go DONE; else NORM.
//  NORM (1..W cyc): carry bit set -> shift right 1 (sticky ORs in), exp+1, go ROUND; if exp+1 reaches all-1s -> Inf, ovf=1, DONE.
//    else if mantissa MSB (hidden position) clear and exp>1 -> shift left 1, exp-1, stay; otherwise go ROUND.
//    MSB clear at exp=1 -> subnormal, exp field packed as 0.
//  ROUND (1 cyc): RNE on guard/round/sticky (round-up if G&(R|S|LSB)). Mantissa carry-out -> exp+1, mant=1.0;
//    exp reaching all-1s -> Inf, ovf=1. Subnormal rounding into hidden bit -> exp field 1. Pack into result -> DONE.
//  DONE: out_valid=1; result, ovf stable until out_ready sampled high; then out_valid=0, IDLE (in_ready=1 next cycle).
//  Latency accept->out_valid: special 1 cycle; normal 4+k cycles, k = NORM cycles (1..W). No accept while busy.
//  Sign of exact zero sum is +0 (x + -x), per mantissa_cal; -0 + -0 = -0 (same-sign path keeps aligned_sign).
//  in_ready, out_valid, busy are registered outputs; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared header (fp defines): `FP32, `GET_EXP_LEN, `GET_MANTISSA_LEN, `GET_PROTECT_LEN, `ADD/`SUB. Add `GET_EXP_LEN there if missing.
//  State encoding (IDLE/ALIGN/CALC/NORM/ROUND/DONE) local parameters in this module only.
//  One sub-module: mantissa_cal (existing), instantiated once with same data_format; no other hierarchy.
// TESTING
//  1.0+1.0: a=0x3F800000 b=0x3F800000 op=0 -> result 0x40000000, ovf=0, one NORM cycle (carry path), out_valid 5 cycles after accept.
//  1.0-1.0: a=0x3F800000 b=0x3F800000 op=1 -> 0x00000000 (+0), NORM skipped, out_valid 3 cycles after accept.
//  1.5+(-1.25): a=0x3FC00000 b=0xBFA00000 op=0 -> 0x3E800000, exactly 3 NORM cycles (2 left shifts + exit).
//  RNE ties: 0x3F800000+0x33800000 -> 0x3F800000; 0x3F800001+0x33800000 -> 0x3F800002.
//  Specials/overflow: 0x7F800000+0xFF800000 -> 0x7FC00000 in 1 cycle; 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, ovf=1.
//  Handshake/reset: out_ready low 5 cycles -> out_valid, result frozen, in_ready=0; rst_n low mid-NORM -> IDLE, out_valid=0, in_ready=1 immediately.

Source files
------------

// File: rtl/fp_addsub_seq_pkg.sv
// Shared FP format macros and helpers for the sequential FP adder.
// Widths derive from the format selector; RNE decision lives here.

`ifndef FP_DEFINES_SVH
`define FP_DEFINES_SVH
`define FP32 0
`define FP64 1
`define GET_EXP_LEN(f) (((f) == `FP64) ? 11 : 8)
`define GET_MANTISSA_LEN(f) (((f) == `FP64) ? 52 : 23)
`define GET_PROTECT_LEN(f) 3
`define ADD 1'b0
`define SUB 1'b1
`endif

package fp_addsub_seq_pkg;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_NAN,
        SP_INF
    } special_t;

    // Round to nearest, ties to even.
    function automatic logic rne_up(
        input logic lsb,
        input logic g,
        input logic r,
        input logic s
    );
        return g & (r | s | lsb);
    endfunction

endpackage

// File: rtl/fp_addsub_seq_mantissa_cal.sv
// Signed-magnitude mantissa add/sub with carry bit.
// Ports: sign_a/b, mant_a/b (W) in; result (W+1), sign out.

module mantissa_cal
    import fp_addsub_seq_pkg::*;
#(
    parameter int data_format = `FP32,
    localparam int M = `GET_MANTISSA_LEN(data_format),
    localparam int P = `GET_PROTECT_LEN(data_format),
    localparam int W = 1 + M + P
) (
    input  logic         sign_a,
    input  logic         sign_b,
    input  logic [W-1:0] mant_a,
    input  logic [W-1:0] mant_b,
    output logic [W:0]   result,
    output logic         sign
);

    always_comb begin
        result = '0;
        sign   = 1'b0;
        if (sign_a == sign_b) begin
            // Same sign keeps the sign even for a zero sum.
            result = {1'b0, mant_a} + {1'b0, mant_b};
            sign   = sign_a;
        end else if (mant_a >= mant_b) begin
            result = {1'b0, mant_a - mant_b};
            // Exact cancellation yields +0.
            sign   = (mant_a == mant_b) ? 1'b0 : sign_a;
        end else begin
            result = {1'b0, mant_b - mant_a};
            sign   = sign_b;
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE add/sub: unpack, align, add, normalise, RNE, pack.
// Ports: clk, rst_n, in_valid/in_ready, a, b, op, out_valid/out_ready, result, ovf, busy.

module fp_addsub_seq
    import fp_addsub_seq_pkg::*;
#(
    parameter int data_format = `FP32,
    localparam int E = `GET_EXP_LEN(data_format),
    localparam int M = `GET_MANTISSA_LEN(data_format),
    localparam int P = `GET_PROTECT_LEN(data_format),
    localparam int N = 1 + E + M,
    localparam int W = 1 + M + P
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         ovf,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        CALC,
        NORM,
        ROUND,
        DONE
    } state_t;

    localparam int SH_W = $clog2(W + 1);
    localparam logic [E-1:0] EXP_MAX = '1;
    localparam logic [E-1:0] EXP_ONE = E'(1);
    localparam logic [E-1:0] DIFF_MAX = E'(W);
    localparam logic [SH_W-1:0] SH_MAX = SH_W'(W);
    localparam logic [N-1:0] QNAN =
        {1'b0, EXP_MAX, 1'b1, {(M-1){1'b0}}};

    state_t       state;
    logic         sign_a;
    logic         sign_b;
    logic [E-1:0] exp_a;
    logic [E-1:0] exp_b;
    logic [W-1:0] mant_a;
    logic [W-1:0] mant_b;
    logic         sign_big;
    logic         sign_small;
    logic [W-1:0] mant_big;
    logic [W-1:0] mant_small;
    logic [E-1:0] exp_r;
    logic [W:0]   cal_result;
    logic         cal_sign;

    // Unpack the incoming operands.
    logic         sa;
    logic         sb;
    logic [E-1:0] ea;
    logic [E-1:0] eb;
    logic [M-1:0] fa;
    logic [M-1:0] fb;
    logic         a_nan;
    logic         b_nan;
    logic         a_inf;
    logic         b_inf;
    special_t     sp;
    logic [N-1:0] inf_word;

    assign sa = a[N-1];
    assign sb = b[N-1] ^ (op == `SUB);
    assign ea = a[N-2:M];
    assign eb = b[N-2:M];
    assign fa = a[M-1:0];
    assign fb = b[M-1:0];
    assign a_nan = (ea == EXP_MAX) && (fa != '0);
    assign b_nan = (eb == EXP_MAX) && (fb != '0);
    assign a_inf = (ea == EXP_MAX) && (fa == '0);
    assign b_inf = (eb == EXP_MAX) && (fb == '0);
    assign inf_word = {a_inf ? sa : sb, EXP_MAX, {M{1'b0}}};

    always_comb begin
        sp = SP_NONE;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            sp = SP_NAN;
        else if (a_inf || b_inf)
            sp = SP_INF;
    end

    // Alignment: larger exponent first, tie keeps a.
    logic            a_first;
    logic [E-1:0]    diff;
    logic [SH_W-1:0] sh;
    logic [W-1:0]    small_raw;
    logic [W-1:0]    small_mask;
    logic [W-1:0]    small_shf;

    assign a_first = exp_a >= exp_b;
    assign diff = a_first ? exp_a - exp_b : exp_b - exp_a;
    assign sh = (diff >= DIFF_MAX) ? SH_MAX : diff[SH_W-1:0];
    assign small_raw = a_first ? mant_b : mant_a;
    // Shifting all-ones by W leaves an all-ones mask: everything is sticky.
    assign small_mask = ~({W{1'b1}} << sh);
    assign small_shf = (small_raw >> sh)
                     | {{(W-1){1'b0}}, |(small_raw & small_mask)};

    logic [W:0] cal_out;
    logic       cal_sign_c;

    mantissa_cal #(
        .data_format(data_format)
    ) u_cal (
        .sign_a(sign_big),
        .sign_b(sign_small),
        .mant_a(mant_big),
        .mant_b(mant_small),
        .result(cal_out),
        .sign  (cal_sign_c)
    );

    // Rounding on guard/round/sticky below the kept mantissa.
    logic [M:0]   keep;
    logic         up;
    logic [M+1:0] rnd;
    logic [E-1:0] exp_inc;

    assign keep = cal_result[W-1:P];
    assign up = rne_up(cal_result[P], cal_result[P-1],
                       cal_result[P-2], |cal_result[P-3:0]);
    assign rnd = {1'b0, keep} + {{(M+1){1'b0}}, up};
    assign exp_inc = exp_r + EXP_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            result     <= '0;
            ovf        <= 1'b0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            exp_a      <= '0;
            exp_b      <= '0;
            mant_a     <= '0;
            mant_b     <= '0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            mant_big   <= '0;
            mant_small <= '0;
            exp_r      <= '0;
            cal_result <= '0;
            cal_sign   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        ovf      <= 1'b0;
                        sign_a   <= sa;
                        sign_b   <= sb;
                        // Subnormals: hidden bit 0, exponent 1.
                        exp_a    <= (ea == '0) ? EXP_ONE : ea;
                        exp_b    <= (eb == '0) ? EXP_ONE : eb;
                        mant_a   <= {|ea, fa, {P{1'b0}}};
                        mant_b   <= {|eb, fb, {P{1'b0}}};
                        unique case (sp)
                            SP_NAN: begin
                                result    <= QNAN;
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end
                            SP_INF: begin
                                result    <= inf_word;
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end
                            default: state <= ALIGN;
                        endcase
                    end
                end
                ALIGN: begin
                    exp_r      <= a_first ? exp_a : exp_b;
                    mant_big   <= a_first ? mant_a : mant_b;
                    sign_big   <= a_first ? sign_a : sign_b;
                    sign_small <= a_first ? sign_b : sign_a;
                    mant_small <= small_shf;
                    state      <= CALC;
                end
                CALC: begin
                    cal_result <= cal_out;
                    cal_sign   <= cal_sign_c;
                    if (cal_out == '0) begin
                        result    <= {cal_sign_c, {(N-1){1'b0}}};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (cal_result[W]) begin
                        cal_result <= {1'b0, cal_result[W:2],
                                       cal_result[1] | cal_result[0]};
                        exp_r <= exp_inc;
                        if (exp_inc == EXP_MAX) begin
                            result    <= {cal_sign, EXP_MAX, {M{1'b0}}};
                            ovf       <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= ROUND;
                        end
                    end else if (!cal_result[W-1] && (exp_r > EXP_ONE)) begin
                        cal_result <= {cal_result[W-1:0], 1'b0};
                        exp_r      <= exp_r - EXP_ONE;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    if (rnd[M+1]) begin
                        // Mantissa wrapped to 10.0: bump the exponent.
                        result <= {cal_sign, exp_inc, {M{1'b0}}};
                        ovf    <= (exp_inc == EXP_MAX);
                    end else begin
                        // Hidden bit clear means subnormal: exp field 0.
                        result <= {cal_sign, rnd[M] ? exp_r : {E{1'b0}},
                                   rnd[M-1:0]};
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq: vector table with scoreboard,
// plus back-pressure and mid-operation reset sequences.

module tb_fp_addsub_seq;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic        ovf;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        ovf;
    logic        busy;

    int checks = 0;
    int errors = 0;
    vec_t exp_q[$];
    vec_t vecs[16];

    fp_addsub_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .ovf      (ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic wait_ready(input string tag);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        vec_t e;
        wait_ready(tag);
        a = v.a;
        b = v.b;
        op = v.op;
        in_valid = 1'b1;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, ".busy"}, {31'b0, busy}, 32'd1);
        wait_out(lat);
        check({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, ".result"}, result, e.res);
            check({tag, ".ovf"}, {31'b0, ovf}, {31'b0, e.ovf});
            check({tag, ".latency"}, 32'(lat), 32'(e.lat));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".released"}, {30'b0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        vec_t v;
        int lat;

        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 5};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 3};
        vecs[2]  = '{32'h3FC00000, 32'hBFA00000, 1'b0, 32'h3E800000, 1'b0, 7};
        vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 5};
        vecs[4]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 5};
        vecs[5]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1};
        vecs[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 4};
        vecs[7]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1};
        vecs[8]  = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1};
        vecs[9]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 3};
        vecs[10] = '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 1'b0, 6};
        vecs[11] = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 5};
        vecs[12] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 1'b0, 5};
        vecs[13] = '{32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 1'b0, 5};
        vecs[14] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0, 6};
        vecs[15] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 1'b1, 5};

        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", {31'b0, in_ready}, 32'd1);
        check("rst.out_valid", {31'b0, out_valid}, 32'd0);
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.ovf", {31'b0, ovf}, 32'd0);
        check("rst.result", result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++)
            run_vec(vecs[i], $sformatf("v%0d", i));

        // Back-pressure: result held while the consumer stalls.
        v = vecs[0];
        wait_ready("bp");
        a = v.a;
        b = v.b;
        op = v.op;
        in_valid = 1'b1;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        a = 32'h40400000;
        wait_out(lat);
        check("bp.out_valid", {31'b0, out_valid}, 32'd1);
        if (exp_q.size() != 0) begin
            v = exp_q.pop_front();
            for (int k = 0; k < 5; k++) begin
                check($sformatf("bp%0d.hold", k),
                      {30'b0, out_valid, in_ready}, 32'd2);
                check($sformatf("bp%0d.result", k), result, v.res);
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp.release", {30'b0, out_valid, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("bp.no_extra", {31'b0, busy}, 32'd0);

        // Reset while the normaliser is shifting.
        a = 32'h3FC00000;
        b = 32'hBFA00000;
        op = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("mid.busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid.in_ready", {31'b0, in_ready}, 32'd1);
        check("mid.out_valid", {31'b0, out_valid}, 32'd0);
        check("mid.busy0", {31'b0, busy}, 32'd0);
        check("mid.result", result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec(vecs[2], "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
